fp32_multiplier: RTL and testbench

- IEEE-754 single-precision (binary32) multiplier with a registered output stage. It sits in the FPU datapath alongside the adder and divider.
- Operands a and b are sampled on the rising clock edge.
- Product and status flags (exception, overflow, underflow) become valid one cycle later.
- Denormals are flushed to zero. No denormal results are produced.

---
 rtl/fp32_multiplier_if.sv | 13 +
 rtl/fp32_multiplier.sv | 105 ++++++++++
 tb/tb_fp32_multiplier.sv | 113 +++++++++++
 3 files changed

// File: rtl/fp32_multiplier_if.sv
// Operand/result bundle for the binary32 multiplier.
// The master drives a/b; the slave (the multiplier) returns res and the status flags.
interface fp32_multiplier_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        exception;
    logic        overflow;
    logic        underflow;
    logic [31:0] res;

    modport master (output a, b, input exception, overflow, underflow, res);
    modport slave  (input a, b, output exception, overflow, underflow, res);
endinterface

// File: rtl/fp32_multiplier.sv
// Binary32 multiplier with one registered output stage; denormals flush to zero.
// Define FP32_MUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp32_multiplier (
    input  logic              clk,
    input  logic              rst_n,
    fp32_multiplier_if.slave  bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic               sign;
    logic [7:0]         ea, eb;
    logic               a_zero, b_zero, a_spec, b_spec;
    logic [47:0]        prod;
    logic               norm;
    logic [23:0]        mant;
    logic               round_up;
    logic [24:0]        mant_r;
    logic [22:0]        mant_f;
    logic signed [9:0]  exp_n, exp_f;

    logic [31:0] res_d, res_q;
    logic        exception_d, exception_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;

    assign sign   = bus.a[31] ^ bus.b[31];
    assign ea     = bus.a[30:23];
    assign eb     = bus.b[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_spec = (ea == 8'hFF);
    assign b_spec = (eb == 8'hFF);
    assign prod   = {1'b1, bus.a[22:0]} * {1'b1, bus.b[22:0]};

`ifdef FP32_MUL_ROUND_NEAREST_EN
    logic guard, rnd, sticky;
    always_comb begin
        guard    = prod[47] ? prod[23] : prod[22];
        rnd      = prod[47] ? prod[22] : prod[21];
        sticky   = prod[47] ? (|prod[21:0]) : (|prod[20:0]);
        round_up = guard & (rnd | sticky | mant[0]);
    end
`else
    // Truncation: the bits below the kept mantissa have no effect.
    logic unused_lo;
    assign unused_lo = ^prod[22:0];
    assign round_up  = 1'b0;
`endif

    always_comb begin
        norm   = prod[47];
        mant   = norm ? prod[47:24] : prod[46:23];
        // 10-bit two's complement keeps the out-of-range exponents visible.
        exp_n  = 10'(ea) + 10'(eb) - 10'd127 + 10'(norm);
        mant_r = {1'b0, mant} + {24'd0, round_up};
        if (mant_r[24]) begin
            mant_f = 23'd0;
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[22:0];
            exp_f  = exp_n;
        end
    end

    always_comb begin
        res_d       = 32'h0000_0000;
        exception_d = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (a_spec || b_spec) begin
            exception_d = 1'b1;
            res_d       = QNAN;
        end else if (a_zero || b_zero) begin
            res_d = 32'h0000_0000;
        end else if (exp_f > 10'sd254) begin
            overflow_d = 1'b1;
            res_d      = {sign, 8'hFF, 23'd0};
        end else if (exp_f < 10'sd1) begin
            underflow_d = 1'b1;
        end else begin
            res_d = {sign, exp_f[7:0], mant_f};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= 32'h0000_0000;
            exception_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            exception_q <= exception_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.res       = res_q;
    assign bus.exception = exception_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed-vector bench for fp32_multiplier: special cases, rounding, throughput, async reset.
module tb_fp32_multiplier;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    fp32_multiplier_if bus ();

    fp32_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FP32_MUL_ROUND_NEAREST_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // flags packed as {exception, overflow, underflow}
    function automatic logic [31:0] flags();
        return {29'd0, bus.exception, bus.overflow, bus.underflow};
    endfunction

    // Present a pair, let one rising edge sample it, then check 1 ns later.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flg);
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        chk({tag, "_res"}, bus.res, exp_res);
        chk({tag, "_flg"}, flags(), {29'd0, exp_flg});
    endtask

    logic [31:0] tp_a [8] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'hBF800000,
                              32'h3F000000, 32'h3FC00000, 32'h40400000, 32'hC0000000};
    logic [31:0] tp_b [8] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h40800000,
                              32'h3F000000, 32'h3FC00000, 32'h40400000, 32'hC0400000};
    logic [31:0] tp_r [8] = '{32'h40C00000, 32'h3F800000, 32'h40800000, 32'hC0800000,
                              32'h3E800000, 32'h40100000, 32'h41100000, 32'h40C00000};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.a  = 32'h7F800000;
        bus.b  = 32'h40000000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", bus.res, 32'h0);
        chk("rst_flg", flags(), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step("mul_2x3",    32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
        step("mul_1234sq", 32'h449A4000, 32'h449A4000, 32'h49B9E220, 3'b000);
        step("zero_zero",  32'h00000000, 32'h00000000, 32'h00000000, 3'b000);
        step("neg_zero",   32'hC1CFE69A, 32'h00000000, 32'h00000000, 3'b000);
        step("neg_sign",   32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
        step("round",      32'h3FC00001, 32'h3FC00001, RND_EXP,      3'b000);
        step("exact",      32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
        step("ovf",        32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
        step("ovf_neg",    32'hFF000000, 32'h40000000, 32'hFF800000, 3'b010);
        step("unf",        32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
        step("exc_inf",    32'h7F800000, 32'h40000000, 32'h7FC00000, 3'b100);
        step("exc_zero",   32'h7FC00000, 32'h00000000, 32'h7FC00000, 3'b100);
        step("denorm",     32'h00400000, 32'h40000000, 32'h00000000, 3'b000);

        // Back-to-back pairs: each result must appear at the very next edge.
        for (int i = 0; i < 8; i++) begin
            bus.a = tp_a[i];
            bus.b = tp_b[i];
            @(posedge clk);
            #1;
            chk($sformatf("tp%0d", i), bus.res, tp_r[i]);
        end

        // Reset mid-stream with an overflow result on the outputs.
        step("pre_rst", 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
        bus.a = 32'h40000000;
        bus.b = 32'h40400000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_res", bus.res, 32'h0);
        chk("async_flg", flags(), 32'h0);
        @(posedge clk);
        #1;
        chk("hold_res", bus.res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'hC0000000, 32'hC0400000, 32'h40C00000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
